multicycle_cpu: RTL
===================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (16 or 32).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter IMEM_ADDR_W, default 32, width of imem_addr.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have imem_req  output  1  fetch request, high while in FETCH.
REQ-007 SHALL have imem_addr  output  IMEM_ADDR_W  byte address of fetch, equals pc[IMEM_ADDR_W-1:0].
REQ-008 SHALL have imem_valid  input  1  fetch data valid this cycle.
REQ-009 SHALL have imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have pc_out  output  32  current PC.
REQ-011 SHALL have retire_valid  output  1  one-cycle pulse per retired instruction.
REQ-012 SHALL have retire_rd  output  5  destination index of retiring instruction.
REQ-013 SHALL have retire_data  output  32  value written (or computed, if rd=x0) by retiring instruction.
REQ-014 SHALL have halted  output  1  core stopped on illegal instruction.

Function
REQ-015 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-016 FETCH: imem_req=1; on imem_valid=1 latch imem_rdata into IR, go DECODE; otherwise stay, unbounded wait.
REQ-017 imem_valid outside FETCH SHALL be ignored.
REQ-018 DECODE: latch rs1/rs2 operands and sign-extended immediate; illegal instruction -> HALT.
REQ-019 EXECUTE: latch ALU result; resolve next PC (pc+4 or branch target).
REQ-020 WRITEBACK: write rd if instruction writes a register; pulse retire_valid; update pc; go FETCH.
REQ-021 Minimum latency SHALL be 4 cycles per instruction (imem_valid in first FETCH cycle).
REQ-022 Supported: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; LUI.
REQ-023 Shifts SHALL use operand b[4:0] only; SLT/SLTI signed, SLTU/SLTIU unsigned; arithmetic mod 2^32.
REQ-024 x0 SHALL read as 0; writes to x0 discarded, but retire still pulses.
REQ-025 Illegal: unknown opcode, undefined funct3/funct7 combination, any rs1/rs2/rd index >= NUM_REGS.
REQ-026 HALT SHALL be terminal until reset: halted=1, imem_req=0, no writes, no retire, pc frozen at illegal instruction address.
REQ-027 PC SHALL wrap modulo 2^32 on pc+4 from 32'hFFFF_FFFC.

Reset
REQ-028 On reset: state=FETCH, pc=RESET_PC, all registers 0, retire_valid=0, retire_rd=0, retire_data=0, halted=0.
REQ-029 imem_req SHALL be 0 during a reset cycle and 1 in the first cycle after reset.
REQ-030 Reset in any state, including mid-fetch or HALT, SHALL abandon the instruction with no register write.

Configuration
REQ-031 Macro MC_CPU_BRANCH_EN defined: BEQ, BNE, BLT, BGE, BLTU, BGEU supported; taken target pc+sext(B-imm); no rd write; retire_rd=0, retire_data=target.
REQ-032 Macro undefined: opcode 1100011 SHALL be illegal -> HALT.

Verification
REQ-033 Reset, imem_valid tied 1, program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3=2, three retire pulses 4 cycles apart, pc_out=12.
REQ-034 SUB x4,x0,x1 (x1=1); SRA x5,x4,x1; SRL x6,x4,x1 -> x5=32'hFFFF_FFFF, x6=32'h7FFF_FFFF; SLT x7,x4,x0=1, SLTU x8,x4,x0=0.
REQ-035 imem_valid delayed 3 cycles per fetch -> instruction period 7 cycles, results identical to REQ-033.
REQ-036 ADDI x0,x0,7 then ADD x1,x0,x0 -> retire_data 7 then 0, x1=0.
REQ-037 NUM_REGS=16, ADDI x20,x0,1 at pc=8 -> halted=1, pc_out=8, no further imem_req until reset; reset -> pc_out=RESET_PC, halted=0.
REQ-038 With MC_CPU_BRANCH_EN, x1=x2=3, BEQ x1,x2,+16 at pc=4 -> next fetch addr 20; without macro -> halted=1 at pc=4.

Source files
------------

// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch bus between the core (master) and instruction memory (slave).
interface multicycle_cpu_if #(
   parameter int IMEM_ADDR_W = 32
);
   logic                   imem_req;
   logic [IMEM_ADDR_W-1:0] imem_addr;
   logic                   imem_valid;
   logic [31:0]            imem_rdata;

   modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I-subset core: FETCH -> DECODE -> EXECUTE -> WRITEBACK, HALT on
// illegal instruction. Define MC_CPU_BRANCH_EN to add conditional branches.
module multicycle_cpu #(
   parameter int          NUM_REGS    = 32,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_cpu_if.master  imem,
   output logic [31:0]       pc_out,
   output logic              retire_valid,
   output logic [4:0]        retire_rd,
   output logic [31:0]       retire_data,
   output logic              halted
);
   localparam int          RI_W   = $clog2(NUM_REGS);
   localparam logic [5:0]  NREGS6 = 6'(NUM_REGS);
   localparam logic [6:0]  OP_R   = 7'b0110011;
   localparam logic [6:0]  OP_I   = 7'b0010011;
   localparam logic [6:0]  OP_LUI = 7'b0110111;
   localparam logic [6:0]  OP_BR  = 7'b1100011;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, npc_q;
   logic [31:0] rf_q [NUM_REGS];
   logic        retire_valid_q, halted_q;
   logic [4:0]  retire_rd_q;
   logic [31:0] retire_data_q;

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign f3     = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign f7     = ir_q[31:25];

   logic        wr_rd;
   assign wr_rd = (opcode != OP_BR);

   // Decode: legality of the opcode/funct combination, register indices in range, operands
   logic        legal, use_rs1, use_rs2, idx_ok, illegal;
   logic [31:0] rs1_val, rs2_val, imm_i, imm_u, opa_d, opb_d;
   always_comb begin
      legal   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            legal   = (f7 == 7'b0000000) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OP_I: begin
            use_rs1 = 1'b1;
            case (f3)
               3'b001:  legal = (f7 == 7'b0000000);
               3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               default: legal = 1'b1;
            endcase
         end
         OP_LUI: legal = 1'b1;
`ifdef MC_CPU_BRANCH_EN
         OP_BR: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            legal   = (f3 != 3'b010) && (f3 != 3'b011);
         end
`endif
         default: legal = 1'b0;
      endcase
      idx_ok  = (!use_rs1 || ({1'b0, rs1} < NREGS6)) &&
                (!use_rs2 || ({1'b0, rs2} < NREGS6)) &&
                (!wr_rd   || ({1'b0, rd}  < NREGS6));
      illegal = !(legal && idx_ok);
      rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[RI_W-1:0]];
      rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[RI_W-1:0]];
      imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
      imm_u   = {ir_q[31:12], 12'd0};
      // LUI is executed as 0 + imm_u through the adder
      opa_d   = (opcode == OP_LUI) ? 32'd0 : rs1_val;
      opb_d   = (opcode == OP_LUI) ? imm_u :
                (opcode == OP_I)   ? imm_i : rs2_val;
   end

   // Execute: ALU result and next PC
   logic [2:0]  op3;
   logic        alt;
   logic [4:0]  shamt;
   logic [31:0] alu_res, exec_res, npc;
   always_comb begin
      op3   = (opcode == OP_LUI) ? 3'b000 : f3;
      // funct7[5] selects SUB/SRA; for immediates only the shift-right encoding carries it
      alt   = (opcode == OP_R) ? f7[5] : ((opcode == OP_I) && (f3 == 3'b101) && f7[5]);
      shamt = b_q[4:0];
      case (op3)
         3'b000:  alu_res = alt ? (a_q - b_q) : (a_q + b_q);
         3'b001:  alu_res = a_q << shamt;
         3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
         3'b011:  alu_res = {31'd0, a_q < b_q};
         3'b100:  alu_res = a_q ^ b_q;
         3'b101:  alu_res = alt ? 32'($signed(a_q) >>> shamt) : (a_q >> shamt);
         3'b110:  alu_res = a_q | b_q;
         default: alu_res = a_q & b_q;
      endcase
      exec_res = alu_res;
      npc      = pc_q + 32'd4;
`ifdef MC_CPU_BRANCH_EN
      if (opcode == OP_BR) begin
         exec_res = pc_q + {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
         case (f3)
            3'b000:  if (a_q == b_q) npc = exec_res;
            3'b001:  if (a_q != b_q) npc = exec_res;
            3'b100:  if ($signed(a_q) <  $signed(b_q)) npc = exec_res;
            3'b101:  if ($signed(a_q) >= $signed(b_q)) npc = exec_res;
            3'b110:  if (a_q <  b_q) npc = exec_res;
            3'b111:  if (a_q >= b_q) npc = exec_res;
            default: npc = pc_q + 32'd4;
         endcase
      end
`endif
   end

   // Main FSM with datapath registers, register file and registered retire outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= FETCH;
         pc_q           <= RESET_PC;
         ir_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         alu_q          <= '0;
         npc_q          <= '0;
         retire_valid_q <= 1'b0;
         retire_rd_q    <= '0;
         retire_data_q  <= '0;
         halted_q       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         retire_valid_q <= 1'b0;
         case (state_q)
            FETCH: if (imem.imem_valid) begin
               ir_q    <= imem.imem_rdata;
               state_q <= DECODE;
            end
            DECODE: if (illegal) begin
               halted_q <= 1'b1;
               state_q  <= HALT;
            end else begin
               a_q     <= opa_d;
               b_q     <= opb_d;
               state_q <= EXECUTE;
            end
            EXECUTE: begin
               alu_q          <= exec_res;
               npc_q          <= npc;
               retire_valid_q <= 1'b1;
               retire_rd_q    <= wr_rd ? rd : 5'd0;
               retire_data_q  <= exec_res;
               state_q        <= WRITEBACK;
            end
            WRITEBACK: begin
               if (wr_rd && rd != 5'd0) rf_q[rd[RI_W-1:0]] <= alu_q;
               pc_q    <= npc_q;
               state_q <= FETCH;
            end
            HALT:    state_q <= HALT;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign imem.imem_req  = (state_q == FETCH) && !reset;
   assign imem.imem_addr = pc_q[IMEM_ADDR_W-1:0];
   assign pc_out         = pc_q;
   assign retire_valid   = retire_valid_q;
   assign retire_rd      = retire_rd_q;
   assign retire_data    = retire_data_q;
   assign halted         = halted_q;
endmodule
